// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: VGA raster counters plus a vertical-blanking arbiter.
// The arbiter grants one framebuffer write window per frame.
// Ports: clk, reset (sync, active-high), pix_en (pixel tick),
//   row/col (raster position), line_start/frame_start (pulses),
//   upd_req/upd_done (game logic), upd_grant, overrun (sticky).
// Option: define VGA_CLKDIV_EN to derive the pixel tick from an
//   internal divide-by-2 toggle instead of pix_en.
module vga_frame_scheduler #(
  parameter int HTOTAL        = 800,
  parameter int VTOTAL        = 525,
  parameter int VACTIVE_LINES = 480,
  parameter int GUARD_LINES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       line_start,
  output logic       frame_start,
  input  logic       upd_req,
  output logic       upd_grant,
  input  logic       upd_done,
  output logic       overrun
);

  localparam logic [9:0] ROW_LAST  = 10'(HTOTAL - 1);
  localparam logic [9:0] COL_LAST  = 10'(VTOTAL - 1);
  localparam logic [9:0] VACT_LAST = 10'(VACTIVE_LINES - 1);
  localparam logic [9:0] GUARD_COL = 10'(VTOTAL - GUARD_LINES);

  typedef enum logic [1:0] {
    ACTIVE,
    VB_WAIT,
    VB_GRANT,
    VB_DONE
  } state_t;

  state_t     r_state;
  logic [9:0] r_row;
  logic [9:0] r_col;
  logic       r_line_start;
  logic       r_frame_start;
  logic       r_grant;
  logic       r_overrun;

  logic w_tick;
  logic w_line_wrap;
  logic w_frame_wrap;
  logic w_enter_vb;
  logic w_guard;

`ifdef VGA_CLKDIV_EN
  logic r_div;
  logic w_unused_pix_en;

  assign w_unused_pix_en = pix_en;

  // Phase is 0 after reset, so the first tick lands on the second clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= 1'b0;
    end else begin
      r_div <= ~r_div;
    end
  end

  assign w_tick = r_div;
`else
  assign w_tick = pix_en;
`endif

  // "Becomes" events: true on the edge where the counters take the value.
  assign w_line_wrap  = w_tick && (r_row == ROW_LAST);
  assign w_frame_wrap = w_line_wrap && (r_col == COL_LAST);
  assign w_enter_vb   = w_line_wrap && (r_col == VACT_LAST);

  // Guard looks at the visible line, so revocation lands one clk later.
  assign w_guard = (r_col >= GUARD_COL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row         <= '0;
      r_col         <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= w_line_wrap;
      r_frame_start <= w_frame_wrap;
      if (w_tick) begin
        if (w_line_wrap) begin
          r_row <= '0;
          r_col <= (r_col == COL_LAST) ? '0 : r_col + 10'd1;
        end else begin
          r_row <= r_row + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ACTIVE;
      r_grant   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // A new overrun in the same cycle overrides this clear.
      if (w_frame_wrap) begin
        r_overrun <= 1'b0;
      end
      unique case (r_state)
        ACTIVE: begin
          if (w_enter_vb) begin
            r_state <= VB_WAIT;
          end
        end
        VB_WAIT: begin
          if (w_frame_wrap) begin
            r_state <= ACTIVE;
          end else if (w_guard) begin
            r_state <= VB_DONE;
          end else if (upd_req) begin
            r_state <= VB_GRANT;
            r_grant <= 1'b1;
          end
        end
        VB_GRANT: begin
          if (upd_done) begin
            r_state <= VB_DONE;
            r_grant <= 1'b0;
          end else if (w_guard) begin
            r_state   <= VB_DONE;
            r_grant   <= 1'b0;
            r_overrun <= 1'b1;
          end
        end
        VB_DONE: begin
          if (w_frame_wrap) begin
            r_state <= ACTIVE;
          end
        end
        default: begin
          r_state <= ACTIVE;
          r_grant <= 1'b0;
        end
      endcase
    end
  end

  assign row         = r_row;
  assign col         = r_col;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign upd_grant   = r_grant;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler: raster table plus arbiter corner sequences.
// Small raster (16x20, 12 active, guard 2) keeps frames short.
module tb_vga_frame_scheduler;

  localparam int H  = 16;
  localparam int V  = 20;
  localparam int VA = 12;
  localparam int G  = 2;
  localparam int GC = V - G;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       upd_req = 1'b0;
  logic       upd_done = 1'b0;
  logic [9:0] row;
  logic [9:0] col;
  logic       line_start;
  logic       frame_start;
  logic       upd_grant;
  logic       overrun;

  always #5 clk = ~clk;

  vga_frame_scheduler #(
    .HTOTAL(H),
    .VTOTAL(V),
    .VACTIVE_LINES(VA),
    .GUARD_LINES(G)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
    .row(row),
    .col(col),
    .line_start(line_start),
    .frame_start(frame_start),
    .upd_req(upd_req),
    .upd_grant(upd_grant),
    .upd_done(upd_done),
    .overrun(overrun)
  );

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int         ticks;
    logic [9:0] row;
    logic [9:0] col;
  } vec_t;

  obs_t exp_q[$];
  vec_t tbl[9];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_row = 0;
  int   m_col = 0;
  int   m_ticks = 0;
  logic m_div = 1'b0;
  int   ls_cnt = 0;
  int   fs_cnt = 0;
  logic g_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic cyc(input logic pe, input logic rq, input logic dn);
    obs_t e;
    obs_t got_e;
    logic tk;
    pix_en   = pe;
    upd_req  = rq;
    upd_done = dn;
`ifdef VGA_CLKDIV_EN
    tk    = m_div;
    m_div = ~m_div;
`else
    tk = pe;
`endif
    e = '0;
    if (tk) begin
      m_ticks++;
      if (m_row == H - 1) begin
        m_row = 0;
        e.ls  = 1'b1;
        if (m_col == V - 1) begin
          m_col = 0;
          e.fs  = 1'b1;
        end else begin
          m_col++;
        end
      end else begin
        m_row++;
      end
    end
    e.row = 10'(m_row);
    e.col = 10'(m_col);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    chk("raster", 32'({row, col, line_start, frame_start}), 32'(got_e));
    chk("grant_in_active", 32'(upd_grant && (m_col < VA)), 32'd0);
    if (line_start) ls_cnt++;
    if (frame_start) fs_cnt++;
    if (upd_grant) g_seen = 1'b1;
  endtask

  task automatic do_reset(input logic rq);
    reset    = 1'b1;
    pix_en   = 1'b0;
    upd_req  = rq;
    upd_done = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_row   = 0;
    m_col   = 0;
    m_div   = 1'b0;
    m_ticks = 0;
    chk("reset_raster", 32'({row, col, line_start, frame_start}), 32'd0);
    chk("reset_arb", 32'({upd_grant, overrun}), 32'd0);
  endtask

  task automatic run_to(input int r, input int c, input logic rq);
    int n;
    n = 0;
    while (!(m_row == r && m_col == c) && n < 4 * H * V) begin
      cyc(1'b1, rq, 1'b0);
      n++;
    end
    if (!(m_row == r && m_col == c)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_to: at row %0d col %0d want row %0d col %0d",
               m_row, m_col, r, c);
    end
  endtask

  initial begin
    tbl = '{
      '{1,   10'd1,  10'd0},
      '{15,  10'd15, 10'd0},
      '{16,  10'd0,  10'd1},
      '{17,  10'd1,  10'd1},
      '{32,  10'd0,  10'd2},
      '{200, 10'd8,  10'd12},
      '{319, 10'd15, 10'd19},
      '{320, 10'd0,  10'd0},
      '{321, 10'd1,  10'd0}
    };

    // Raster walk through one full frame and the wrap.
    do_reset(1'b0);
    ls_cnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      int n;
      n = 0;
      while (m_ticks < tbl[i].ticks && n < 2000) begin
        cyc(1'b1, 1'b0, 1'b0);
        n++;
      end
      chk($sformatf("tbl%0d_row", i), 32'(row), 32'(tbl[i].row));
      chk($sformatf("tbl%0d_col", i), 32'(col), 32'(tbl[i].col));
    end
    chk("line_start_count", 32'(ls_cnt), 32'd20);
    chk("frame_start_count", 32'(fs_cnt), 32'd1);

    // Grant at blanking entry, released by upd_done.
    do_reset(1'b0);
    run_to(0, VA, 1'b1);
    chk("grant_at_vb_entry", 32'(upd_grant), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("grant_after_vb", 32'(upd_grant), 32'd1);
    run_to(0, 14, 1'b1);
    chk("grant_held", 32'(upd_grant), 32'd1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("grant_done_drop", 32'(upd_grant), 32'd0);
    chk("done_no_overrun", 32'(overrun), 32'd0);
    g_seen = 1'b0;
    run_to(15, 19, 1'b1);
    chk("one_grant_per_frame", 32'(g_seen), 32'd0);

    // Guard revokes a grant and sets overrun.
    do_reset(1'b0);
    run_to(0, GC, 1'b1);
    chk("grant_at_guard", 32'(upd_grant), 32'd1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("guard_drop", 32'(upd_grant), 32'd0);
    chk("overrun_set", 32'(overrun), 32'd1);
    run_to(15, 19, 1'b1);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("overrun_clear_fs", 32'({frame_start, overrun}), 32'd2);
    run_to(0, VA, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("regrant_next_frame", 32'(upd_grant), 32'd1);

    // upd_done on the guard line wins over the revoke.
    do_reset(1'b0);
    run_to(0, GC, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("done_prec_grant", 32'(upd_grant), 32'd0);
    chk("done_prec_overrun", 32'(overrun), 32'd0);

    // No request before the guard: late request is ignored.
    do_reset(1'b0);
    run_to(0, GC, 1'b0);
    g_seen = 1'b0;
    run_to(15, 19, 1'b1);
    chk("late_req_ignored", 32'(g_seen), 32'd0);

    // Reset in the middle of a grant.
    do_reset(1'b0);
    run_to(0, 15, 1'b1);
    chk("grant_before_rst", 32'(upd_grant), 32'd1);
    do_reset(1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("no_grant_after_rst", 32'(upd_grant), 32'd0);

    // Tick rate: pix_en 1-in-4, or internal /2 when enabled.
    do_reset(1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc((k % 4) == 0, 1'b0, 1'b0);
    end
`ifdef VGA_CLKDIV_EN
    chk("tick_rate_row", 32'(row), 32'd6);
`else
    chk("tick_rate_row", 32'(row), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_scheduler.md
VGA_FRAME_SCHEDULER -- requirements
Module: vga_frame_scheduler

Interface
REQ-001 Parameter HTOTAL, default 800, pixels per line (active 640 + porches + sync).
REQ-002 Parameter VTOTAL, default 525, lines per frame (active 480 + porches + sync).
REQ-003 Parameter VACTIVE_LINES, default 480, last active line + 1; vertical blanking is lines VACTIVE_LINES..VTOTAL-1.
REQ-004 Parameter GUARD_LINES, default 2, lines before frame end at which any update grant is revoked.
REQ-005 The module SHALL be clocked by a single clock port clk; reset SHALL be the synchronous, active-high port reset.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 pix_en  in  1  pixel-rate enable tick (ignored when VGA_CLKDIV_EN is defined).
REQ-009 row  out  10  horizontal pixel counter, 0..HTOTAL-1.
REQ-010 col  out  10  vertical line counter, 0..VTOTAL-1.
REQ-011 line_start  out  1  one-clk pulse when row becomes 0.
REQ-012 frame_start  out  1  one-clk pulse when row and col both become 0.
REQ-013 upd_req  in  1  game logic requests framebuffer write window.
REQ-014 upd_grant  out  1  framebuffer write access granted.
REQ-015 upd_done  in  1  game logic releases grant.
REQ-016 overrun  out  1  sticky flag: grant revoked by guard before upd_done.

Function
REQ-017 On a cycle with effective pixel tick, row SHALL increment by 1; at HTOTAL-1 it SHALL wrap to 0 and col SHALL increment by 1, wrapping from VTOTAL-1 to 0.
REQ-018 All outputs SHALL be registered; counter changes appear the cycle after the tick is sampled; with no tick, row/col SHALL hold.
REQ-019 line_start SHALL assert for exactly one clk in the cycle row becomes 0; frame_start only when col also becomes 0.
REQ-020 Arbiter FSM states: ACTIVE, VB_WAIT, VB_GRANT, VB_DONE.
REQ-021 ACTIVE -> VB_WAIT when col becomes VACTIVE_LINES.
REQ-022 VB_WAIT -> VB_GRANT (upd_grant=1 next clk) when upd_req=1 and col < VTOTAL-GUARD_LINES.
REQ-023 VB_GRANT -> VB_DONE (upd_grant=0 next clk) on upd_done=1.
REQ-024 VB_GRANT -> VB_DONE with overrun set when col becomes VTOTAL-GUARD_LINES and upd_done=0 that cycle; upd_done=1 in the same cycle SHALL take precedence (no overrun).
REQ-025 VB_WAIT -> VB_DONE when col reaches VTOTAL-GUARD_LINES without request; at most one grant per frame.
REQ-026 VB_WAIT/VB_DONE -> ACTIVE on frame_start; upd_grant SHALL never be 1 while col < VACTIVE_LINES.
REQ-027 upd_req held high in VB_DONE or ACTIVE SHALL be ignored until the next VB_WAIT.
REQ-028 overrun SHALL clear only on frame_start in which no new overrun occurs, or on reset.

Reset
REQ-029 reset SHALL set row=0, col=0, line_start=0, frame_start=0, upd_grant=0, overrun=0, FSM=ACTIVE, divider phase=0, on the next clk edge.
REQ-030 Reset asserted mid-grant SHALL drop upd_grant on the next clk without setting overrun.

Configuration
REQ-031 With macro VGA_CLKDIV_EN defined, the effective pixel tick SHALL be an internal divide-by-2 toggle (tick on every second clk, first tick the second clk after reset release) and pix_en SHALL be ignored.
REQ-032 Without VGA_CLKDIV_EN, the effective pixel tick SHALL be pix_en directly.

Verification
REQ-033 pix_en=1 constantly, 800x525 ticks from reset -> row wraps 799->0 with line_start each line, col wraps 524->0, one frame_start per 420000 ticks.
REQ-034 upd_req=1 from row 0 col 0 -> upd_grant=1 one clk after col becomes 480; upd_done pulse at col 490 -> upd_grant=0 next clk, overrun=0.
REQ-035 upd_req=1, upd_done never -> upd_grant falls one clk after col becomes 523, overrun=1, cleared at following clean frame_start.
REQ-036 upd_done=1 in the same cycle col becomes 523 -> grant drops, overrun stays 0.
REQ-037 reset pulse while upd_grant=1 at col 500 -> next clk row=0, col=0, upd_grant=0, overrun=0.
REQ-038 VGA_CLKDIV_EN defined, pix_en=0 -> row advances every second clk; undefined, pix_en toggled 1-in-4 -> row advances every fourth clk.
